// File: rtl/watch_ctrl_pkg.sv
// rtl/watch_ctrl_pkg.sv - shared state encoding and default timing constants for the watch control FSM
package watch_ctrl_pkg;

    typedef enum logic [2:0] {
        SW_STOP  = 3'd0,
        SW_RUN   = 3'd1,
        SW_CLEAR = 3'd2,
        W_VIEW   = 3'd3,
        W_EDIT   = 3'd4
    } state_t;

    localparam int DEF_N_FIELDS      = 4;
    localparam int DEF_HOLD_CYCLES   = 50_000_000;
    localparam int DEF_REPEAT_CYCLES = 10_000_000;
    localparam int DEF_BLINK_CYCLES  = 25_000_000;
    localparam int DEF_EDIT_TIMEOUT  = 500_000_000;

    function automatic logic is_sw_state(input state_t s);
        return (s == SW_STOP) || (s == SW_RUN) || (s == SW_CLEAR);
    endfunction

endpackage

// File: rtl/btn_hold_repeat.sv
// rtl/btn_hold_repeat.sv - auto-repeat pulse generator for a held, already-synchronised button level
module btn_hold_repeat #(
    parameter int HOLD_CYCLES   = 50_000_000,
    parameter int REPEAT_CYCLES = 10_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic i_btn,
    input  logic i_en,
    output logic o_pulse
);

    localparam int CW = $clog2(HOLD_CYCLES) + 1;
    localparam logic [CW-1:0] HOLD_C  = CW'(HOLD_CYCLES);
    localparam logic [CW-1:0] REP_C   = CW'(REPEAT_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = '1;

    logic [CW-1:0] cnt;
    logic          repeating;
    logic          active;

    // cnt holds the number of cycles the level has been seen high since the
    // last pulse (or since the press), so the compare fires on the target cycle
    assign active  = i_en & i_btn;
    assign o_pulse = active & (cnt == (repeating ? REP_C : HOLD_C));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt       <= '0;
            repeating <= 1'b0;
        end else if (!active) begin
            cnt       <= '0;
            repeating <= 1'b0;
        end else if (o_pulse) begin
            cnt       <= CW'(1);
            repeating <= 1'b1;
        end else if (cnt != CNT_MAX) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/watch_ctrl_fsm.sv
// rtl/watch_ctrl_fsm.sv - watch/stopwatch control FSM with time-edit mode, registered outputs
module watch_ctrl_fsm
    import watch_ctrl_pkg::*;
#(
    parameter int N_FIELDS      = DEF_N_FIELDS,
    parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
    parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES,
    parameter int BLINK_CYCLES  = DEF_BLINK_CYCLES,
    parameter int EDIT_TIMEOUT  = DEF_EDIT_TIMEOUT,
    localparam int FW           = (N_FIELDS > 1) ? $clog2(N_FIELDS) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_stopwatch,
    input  logic          i_down,
    input  logic          i_btn_run,
    input  logic          i_btn_clear,
    input  logic          i_btn_edit,
    input  logic          i_btn_up,
    input  logic          i_btn_down,
    output logic          o_stopwatch,
    output logic          o_run_stop,
    output logic          o_clear,
    output logic          o_down,
    output logic          o_lap_hold,
    output logic          o_edit_active,
    output logic [FW-1:0] o_edit_field,
    output logic          o_inc,
    output logic          o_dec,
    output logic          o_blink
);

    localparam int BW = $clog2(BLINK_CYCLES) + 1;
    localparam int TW = $clog2(EDIT_TIMEOUT) + 1;
    localparam logic [FW-1:0] TOP_FIELD  = FW'(N_FIELDS - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST    = TW'(EDIT_TIMEOUT - 1);
    localparam logic [TW-1:0] TO_MAX     = '1;

    state_t        state;
    logic          sw_running;
    logic [BW-1:0] blink_cnt;
    logic [TW-1:0] to_cnt;

    logic sw_r, down_r;
    logic run_r, clr_r, edit_r, up_r, dn_r;
    logic run_q, clr_q, edit_q, up_q, dn_q;

    // Inputs are registered once before edge detection; this stage is what
    // gives the one-extra-edge latency from a level to its output effect.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sw_r   <= 1'b0;
            down_r <= 1'b0;
            run_r  <= 1'b0;
            clr_r  <= 1'b0;
            edit_r <= 1'b0;
            up_r   <= 1'b0;
            dn_r   <= 1'b0;
            run_q  <= 1'b0;
            clr_q  <= 1'b0;
            edit_q <= 1'b0;
            up_q   <= 1'b0;
            dn_q   <= 1'b0;
        end else begin
            sw_r   <= i_stopwatch;
            down_r <= i_down;
            run_r  <= i_btn_run;
            clr_r  <= i_btn_clear;
            edit_r <= i_btn_edit;
            up_r   <= i_btn_up;
            dn_r   <= i_btn_down;
            run_q  <= run_r;
            clr_q  <= clr_r;
            edit_q <= edit_r;
            up_q   <= up_r;
            dn_q   <= dn_r;
        end
    end

    logic run_rise, clr_rise, edit_rise, up_rise, dn_rise;
    logic up_rep, dn_rep, edit_en;
    logic fire_inc, fire_dec, activity;

    assign run_rise  = run_r & ~run_q;
    assign clr_rise  = clr_r & ~clr_q;
    assign edit_rise = edit_r & ~edit_q;
    assign up_rise   = up_r & ~up_q;
    assign dn_rise   = dn_r & ~dn_q;
    assign edit_en   = (state == W_EDIT);

    btn_hold_repeat #(
        .HOLD_CYCLES   (HOLD_CYCLES),
        .REPEAT_CYCLES (REPEAT_CYCLES)
    ) u_up_repeat (
        .clk     (clk),
        .reset   (reset),
        .i_btn   (up_r),
        .i_en    (edit_en),
        .o_pulse (up_rep)
    );

    btn_hold_repeat #(
        .HOLD_CYCLES   (HOLD_CYCLES),
        .REPEAT_CYCLES (REPEAT_CYCLES)
    ) u_dn_repeat (
        .clk     (clk),
        .reset   (reset),
        .i_btn   (dn_r),
        .i_en    (edit_en),
        .o_pulse (dn_rep)
    );

    // Edit beats up beats down; a simultaneous up+down press cancels both.
    assign fire_inc = ~edit_rise & ~(up_rise & dn_rise) & (up_rise | up_rep);
    assign fire_dec = ~edit_rise & ~(up_rise & dn_rise) & ~(up_rise | up_rep) & (dn_rise | dn_rep);
    assign activity = run_rise | clr_rise | edit_rise | up_rise | dn_rise | up_rep | dn_rep;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= W_VIEW;
            sw_running    <= 1'b0;
            o_stopwatch   <= 1'b0;
            o_run_stop    <= 1'b0;
            o_clear       <= 1'b0;
            o_down        <= 1'b0;
            o_lap_hold    <= 1'b0;
            o_edit_active <= 1'b0;
            o_edit_field  <= TOP_FIELD;
            o_inc         <= 1'b0;
            o_dec         <= 1'b0;
            o_blink       <= 1'b1;
            blink_cnt     <= '0;
            to_cnt        <= '0;
        end else begin
            o_clear <= 1'b0;
            o_inc   <= 1'b0;
            o_dec   <= 1'b0;
            if (state == SW_STOP) begin
                o_down <= down_r;
            end

            if (is_sw_state(state) && !sw_r) begin
                state       <= W_VIEW;
                o_stopwatch <= 1'b0;
            end else if (!is_sw_state(state) && sw_r) begin
                // Also aborts a pending edit without touching the counters.
                state         <= sw_running ? SW_RUN : SW_STOP;
                o_stopwatch   <= 1'b1;
                o_edit_active <= 1'b0;
                o_edit_field  <= TOP_FIELD;
                o_blink       <= 1'b1;
            end else begin
                case (state)
                    SW_STOP: begin
                        if (run_rise) begin
                            state      <= SW_RUN;
                            sw_running <= 1'b1;
                            o_run_stop <= 1'b1;
                        end else if (clr_rise) begin
                            if (o_lap_hold) begin
                                o_lap_hold <= 1'b0;
                            end else begin
                                state   <= SW_CLEAR;
                                o_clear <= 1'b1;
                            end
                        end
                    end
                    SW_RUN: begin
                        if (run_rise) begin
                            state      <= SW_STOP;
                            sw_running <= 1'b0;
                            o_run_stop <= 1'b0;
                        end else if (clr_rise) begin
                            o_lap_hold <= ~o_lap_hold;
                        end
                    end
                    SW_CLEAR: begin
                        state <= SW_STOP;
                    end
                    W_VIEW: begin
                        if (edit_rise) begin
                            state         <= W_EDIT;
                            o_edit_active <= 1'b1;
                            o_edit_field  <= TOP_FIELD;
                            o_blink       <= 1'b1;
                            blink_cnt     <= '0;
                            to_cnt        <= '0;
                        end
                    end
                    W_EDIT: begin
                        o_inc <= fire_inc;
                        o_dec <= fire_dec;
                        if (fire_inc || fire_dec) begin
                            o_blink   <= 1'b1;
                            blink_cnt <= '0;
                        end else if (blink_cnt == BLINK_LAST) begin
                            o_blink   <= ~o_blink;
                            blink_cnt <= '0;
                        end else begin
                            blink_cnt <= blink_cnt + BW'(1);
                        end

                        if (activity) begin
                            to_cnt <= '0;
                        end else if (to_cnt != TO_MAX) begin
                            to_cnt <= to_cnt + TW'(1);
                        end

                        // Exit assignments come last so they override the blink update.
                        if ((edit_rise && o_edit_field == '0) || (!activity && to_cnt == TO_LAST)) begin
                            state         <= W_VIEW;
                            o_edit_active <= 1'b0;
                            o_edit_field  <= TOP_FIELD;
                            o_blink       <= 1'b1;
                        end else if (edit_rise) begin
                            o_edit_field <= o_edit_field - FW'(1);
                        end
                    end
                    default: begin
                        state <= W_VIEW;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_watch_ctrl_fsm.sv
// tb/tb_watch_ctrl_fsm.sv - directed scoreboard bench for watch_ctrl_fsm
module tb_watch_ctrl_fsm;

    localparam int S_SW = 0, S_RUN = 1, S_CLR = 2, S_DOWN = 3, S_LAP = 4;
    localparam int S_EDIT = 5, S_FIELD = 6, S_INC = 7, S_DEC = 8, S_BLINK = 9;
    localparam int B_RUN = 0, B_CLR = 1, B_EDIT = 2, B_UP = 3, B_DN = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       i_stopwatch, i_down, i_btn_run, i_btn_clear, i_btn_edit, i_btn_up, i_btn_down;
    logic       o_stopwatch, o_run_stop, o_clear, o_down, o_lap_hold, o_edit_active;
    logic [1:0] o_edit_field;
    logic       o_inc, o_dec, o_blink;

    typedef struct {
        string      tag;
        int         sig;
        logic [7:0] val;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    watch_ctrl_fsm #(
        .N_FIELDS      (4),
        .HOLD_CYCLES   (8),
        .REPEAT_CYCLES (4),
        .BLINK_CYCLES  (3),
        .EDIT_TIMEOUT  (20)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .i_stopwatch   (i_stopwatch),
        .i_down        (i_down),
        .i_btn_run     (i_btn_run),
        .i_btn_clear   (i_btn_clear),
        .i_btn_edit    (i_btn_edit),
        .i_btn_up      (i_btn_up),
        .i_btn_down    (i_btn_down),
        .o_stopwatch   (o_stopwatch),
        .o_run_stop    (o_run_stop),
        .o_clear       (o_clear),
        .o_down        (o_down),
        .o_lap_hold    (o_lap_hold),
        .o_edit_active (o_edit_active),
        .o_edit_field  (o_edit_field),
        .o_inc         (o_inc),
        .o_dec         (o_dec),
        .o_blink       (o_blink)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] obs(input int s);
        case (s)
            S_SW:    return {7'd0, o_stopwatch};
            S_RUN:   return {7'd0, o_run_stop};
            S_CLR:   return {7'd0, o_clear};
            S_DOWN:  return {7'd0, o_down};
            S_LAP:   return {7'd0, o_lap_hold};
            S_EDIT:  return {7'd0, o_edit_active};
            S_FIELD: return {6'd0, o_edit_field};
            S_INC:   return {7'd0, o_inc};
            S_DEC:   return {7'd0, o_dec};
            S_BLINK: return {7'd0, o_blink};
            default: return 8'hxx;
        endcase
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input int s, input logic [7:0] v);
        sb.push_back('{tag, s, v});
    endtask

    task automatic check_out();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            assert (obs(e.sig) === e.val)
            else begin
                failures++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, obs(e.sig), e.val);
            end
        end
    endtask

    task automatic set_btn(input int b, input logic v);
        case (b)
            B_RUN:   i_btn_run   = v;
            B_CLR:   i_btn_clear = v;
            B_EDIT:  i_btn_edit  = v;
            B_UP:    i_btn_up    = v;
            default: i_btn_down  = v;
        endcase
    endtask

    // One-sample press; on return the effect of the rise is visible.
    task automatic press(input int b);
        set_btn(b, 1'b1);
        tick(1);
        set_btn(b, 1'b0);
        tick(1);
    endtask

    task automatic expect_reset_values(input string pfx);
        expect_out({pfx, "_sw"},    S_SW,    8'd0);
        expect_out({pfx, "_run"},   S_RUN,   8'd0);
        expect_out({pfx, "_clr"},   S_CLR,   8'd0);
        expect_out({pfx, "_down"},  S_DOWN,  8'd0);
        expect_out({pfx, "_lap"},   S_LAP,   8'd0);
        expect_out({pfx, "_edit"},  S_EDIT,  8'd0);
        expect_out({pfx, "_field"}, S_FIELD, 8'd3);
        expect_out({pfx, "_inc"},   S_INC,   8'd0);
        expect_out({pfx, "_dec"},   S_DEC,   8'd0);
        expect_out({pfx, "_blink"}, S_BLINK, 8'd1);
    endtask

    initial begin
        reset = 1'b1;
        i_stopwatch = 1'b0; i_down = 1'b0;
        i_btn_run = 1'b0; i_btn_clear = 1'b0; i_btn_edit = 1'b0;
        i_btn_up = 1'b0; i_btn_down = 1'b0;
        tick(2);
        expect_reset_values("rst");
        check_out();
        reset = 1'b0;
        tick(1);

        // stopwatch run/stop, direction latch, clear
        i_stopwatch = 1'b1; i_down = 1'b1;
        tick(2);
        expect_out("sw_entry", S_SW, 8'd1);
        expect_out("sw_entry_run", S_RUN, 8'd0);
        check_out();
        press(B_RUN);
        expect_out("run_start", S_RUN, 8'd1);
        expect_out("down_latched", S_DOWN, 8'd1);
        check_out();
        i_down = 1'b0;
        tick(3);
        expect_out("down_frozen", S_DOWN, 8'd1);
        check_out();
        press(B_RUN);
        expect_out("run_stop", S_RUN, 8'd0);
        check_out();
        tick(2);
        expect_out("down_reload", S_DOWN, 8'd0);
        check_out();
        press(B_CLR);
        expect_out("clear_pulse", S_CLR, 8'd1);
        check_out();
        tick(1);
        expect_out("clear_one_cycle", S_CLR, 8'd0);
        check_out();

        // lap hold
        press(B_RUN);
        press(B_CLR);
        expect_out("lap_set", S_LAP, 8'd1);
        expect_out("lap_running", S_RUN, 8'd1);
        check_out();
        press(B_RUN);
        expect_out("lap_stop_run", S_RUN, 8'd0);
        expect_out("lap_kept", S_LAP, 8'd1);
        check_out();
        press(B_CLR);
        expect_out("lap_release", S_LAP, 8'd0);
        expect_out("lap_release_noclr", S_CLR, 8'd0);
        check_out();
        press(B_CLR);
        expect_out("clear_after_lap", S_CLR, 8'd1);
        check_out();
        tick(1);

        // background running across mode switch
        press(B_RUN);
        expect_out("bg_run", S_RUN, 8'd1);
        check_out();
        i_stopwatch = 1'b0;
        tick(2);
        expect_out("bg_watch_sw", S_SW, 8'd0);
        expect_out("bg_watch_run", S_RUN, 8'd1);
        check_out();
        i_stopwatch = 1'b1;
        tick(2);
        expect_out("bg_back_sw", S_SW, 8'd1);
        expect_out("bg_back_run", S_RUN, 8'd1);
        check_out();
        press(B_RUN);
        expect_out("bg_back_in_run", S_RUN, 8'd0);
        check_out();
        i_stopwatch = 1'b0;
        tick(2);
        expect_out("to_watch", S_SW, 8'd0);
        check_out();

        // field walk through edit
        press(B_EDIT);
        expect_out("edit_enter", S_EDIT, 8'd1);
        expect_out("edit_enter_field", S_FIELD, 8'd3);
        expect_out("edit_enter_blink", S_BLINK, 8'd1);
        check_out();
        for (int f = 2; f >= 0; f--) begin
            press(B_EDIT);
            expect_out("edit_field_step", S_FIELD, 8'(f));
            expect_out("edit_still_active", S_EDIT, 8'd1);
            check_out();
        end
        press(B_EDIT);
        expect_out("edit_wrap_exit", S_EDIT, 8'd0);
        expect_out("edit_wrap_field", S_FIELD, 8'd3);
        check_out();

        // blink half-period
        press(B_EDIT);
        tick(3);
        expect_out("blink_toggle", S_BLINK, 8'd0);
        check_out();

        // hold-to-repeat on up
        i_btn_up = 1'b1;
        for (int t = 1; t <= 23; t++) begin
            tick(1);
            if (t == 20) i_btn_up = 1'b0;
            if (t >= 2) begin
                automatic int  m = t - 1;
                automatic logic p = (m == 1) || (m == 9) || (m == 13) || (m == 17);
                expect_out($sformatf("hold_inc_m%0d", m), S_INC, {7'd0, p});
                expect_out($sformatf("hold_dec_m%0d", m), S_DEC, 8'd0);
                if (p) expect_out($sformatf("hold_blink_m%0d", m), S_BLINK, 8'd1);
                check_out();
            end
        end

        // idle timeout, restarted by a clear rise
        press(B_CLR);
        tick(19);
        expect_out("timeout_not_yet", S_EDIT, 8'd1);
        check_out();
        tick(1);
        expect_out("timeout_exit", S_EDIT, 8'd0);
        expect_out("timeout_field", S_FIELD, 8'd3);
        check_out();

        // dec pulse and cancelled simultaneous press
        press(B_EDIT);
        press(B_DN);
        expect_out("dec_pulse", S_DEC, 8'd1);
        expect_out("dec_no_inc", S_INC, 8'd0);
        expect_out("dec_blink", S_BLINK, 8'd1);
        check_out();
        tick(1);
        expect_out("dec_one_cycle", S_DEC, 8'd0);
        check_out();
        i_btn_up = 1'b1; i_btn_down = 1'b1;
        tick(1);
        i_btn_up = 1'b0; i_btn_down = 1'b0;
        tick(1);
        expect_out("updn_inc", S_INC, 8'd0);
        expect_out("updn_dec", S_DEC, 8'd0);
        check_out();

        // asynchronous reset in the middle of an edit pulse
        press(B_UP);
        expect_out("pre_reset_inc", S_INC, 8'd1);
        check_out();
        reset = 1'b1;
        #1;
        expect_reset_values("mid_rst");
        check_out();
        reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
